ex_mem_pipe_stage: RTL and testbench
====================================

// Module: ex_mem_pipe_stage
// PURPOSE
//  Parametrised EX->MEM pipeline stage with valid/ready handshake, stall, flush and an optional skid entry.
//  Replaces the free-running EX/MEM register in the pipelined core, so that the MEM stage can back-pressure EX.
//  The MEM stage then never sees stale control: control outputs read zero whenever the stage holds no valid beat.
//  Also counts back-pressure cycles for performance debug.
// PARAMETERS
//  DATA_SIZE  32  width of ALU result and store data
//  ADDR_SIZE  10  instruction address width; jump target is ADDR_SIZE+2 bits
//  CTRL_W     8   packed control bundle {branch,reg_write,mem_read,mem_write,mem_to_reg[1:0],AuipcLui[1:0]}
//  SKID       1   1: 2-entry skid buffer, ready_ex registered; 0: single entry, ready_ex combinational
// PORTS
//  clk                     in   1            rising-edge clock
//  clear                   in   1            synchronous active-high reset
//  flush                   in   1            sync kill of held and incoming beats (branch taken)
//  valid_ex                in   1            EX presents a beat
//  ready_ex                out  1            stage accepts beat this cycle
//  ctrl_ex                 in   CTRL_W       control bundle
//  inst_11_to_7_ex         in   5            rd
//  inst_14_to_12_ex        in   3            funct3
//  jump_alu_result_ex      in   ADDR_SIZE+2  branch/jump target
//  address_alu_result_ex   in   DATA_SIZE    ALU result / memory address
//  address_alu_zero_ex     in   1            ALU zero flag
//  read_data_2_ex          in   DATA_SIZE    store data
//  valid_mem               out  1            stage holds a valid beat
//  ready_mem               in   1            MEM consumes the beat this cycle
//  ctrl_mem .. read_data_2_mem  out  (same widths as _ex)  registered copies
//  stall_cycles            out  16           saturating back-pressure counter
// BEHAVIOUR
//  - Transfers: in = valid_ex & ready_ex; out = valid_mem & ready_mem.
//  - Reset (clear=1 at clk edge): valid_mem=0, skid empty, all _mem payload=0, stall_cycles=0, ready_ex=1 next cycle.
//  - clear has priority over flush, and flush has priority over all transfers.
//  - Flush: next cycle valid_mem=0, skid empty; the beat offered in the flush cycle is dropped.
//    Flush leaves payload registers and stall_cycles unchanged.
//  - ctrl_mem = valid_mem ? main_ctrl : 0. Payload fields are not gated.
//  - Latency: accepted beat appears on _mem outputs 1 cycle later when the stage was EMPTY, or was FULL with ready_mem=1.
//  - Order is preserved: main always older than skid.
//  - SKID=1 state machine (ready_ex = state!=SKIDFULL, from a flop):
//    EMPTY:    valid_ex -> load main, FULL
//    FULL:     ready_mem & valid_ex -> reload main, FULL;  ready_mem & !valid_ex -> EMPTY
//              !ready_mem & valid_ex -> load skid, SKIDFULL;  else hold
//    SKIDFULL: ready_mem -> main<=skid, FULL; else hold. valid_ex is ignored.
//  - SKID=0: states EMPTY/FULL only; ready_ex = ready_mem | !valid_mem (combinational).
//  - Held beat: all _mem outputs stable while valid_mem & !ready_mem.
//  - stall_cycles: +1 each cycle valid_mem & !ready_mem & !clear; saturates at 16'hFFFF (no wrap).
//  - ready_mem while valid_mem=0 has no effect.
//  - valid_ex while ready_ex=0 has no effect; upstream holds its beat.
// TESTING
//  1 clear=1 one cycle, then idle: valid_mem=0, ctrl_mem=0, stall_cycles=0, ready_ex=1.
//  2 Stream: ready_mem=1, beats A0..A3 (address_alu_result 0x10..0x13) back-to-back.
//    -> _mem shows 0x10..0x13 on consecutive cycles, 1-cycle latency.
//  3 SKID=1: hold ready_mem=0, send 0x20,0x21,0x22.
//    -> 0x20 held, 0x21 in skid, ready_ex=0 from cycle 3, 0x22 waits.
//    -> release ready_mem: 0x20,0x21,0x22 in order; stall_cycles counts held cycles.
//  4 Flush in SKIDFULL with valid_ex=1 -> next cycle valid_mem=0, ctrl_mem=0, ready_ex=1; no beat reappears.
//  5 clear and flush together mid-stream -> reset values above.
//    Counter saturation: preload via 65540 stall cycles -> stall_cycles=16'hFFFF.
//  6 Repeat 2-4 with SKID=0, ADDR_SIZE=12: ready_ex tracks ready_mem combinationally; jump target 14 bits passes intact.

Source files
------------

// File: rtl/ex_mem_if.sv
// EX->MEM beat channel: EX-side inputs, MEM-side registered outputs and the two handshakes.
// Handshake: a beat moves when valid and ready are both high at the rising clock edge; a producer holds its beat until then.
interface ex_mem_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10,
  parameter int CTRL_W    = 8
);
  logic                   valid_ex;
  logic                   ready_ex;
  logic [CTRL_W-1:0]      ctrl_ex;
  logic [4:0]             inst_11_to_7_ex;
  logic [2:0]             inst_14_to_12_ex;
  logic [ADDR_SIZE+1:0]   jump_alu_result_ex;
  logic [DATA_SIZE-1:0]   address_alu_result_ex;
  logic                   address_alu_zero_ex;
  logic [DATA_SIZE-1:0]   read_data_2_ex;

  logic                   valid_mem;
  logic                   ready_mem;
  logic [CTRL_W-1:0]      ctrl_mem;
  logic [4:0]             inst_11_to_7_mem;
  logic [2:0]             inst_14_to_12_mem;
  logic [ADDR_SIZE+1:0]   jump_alu_result_mem;
  logic [DATA_SIZE-1:0]   address_alu_result_mem;
  logic                   address_alu_zero_mem;
  logic [DATA_SIZE-1:0]   read_data_2_mem;

  modport slave (
    input  valid_ex, ctrl_ex, inst_11_to_7_ex, inst_14_to_12_ex, jump_alu_result_ex,
           address_alu_result_ex, address_alu_zero_ex, read_data_2_ex, ready_mem,
    output ready_ex, valid_mem, ctrl_mem, inst_11_to_7_mem, inst_14_to_12_mem,
           jump_alu_result_mem, address_alu_result_mem, address_alu_zero_mem, read_data_2_mem
  );

  modport master (
    output valid_ex, ctrl_ex, inst_11_to_7_ex, inst_14_to_12_ex, jump_alu_result_ex,
           address_alu_result_ex, address_alu_zero_ex, read_data_2_ex, ready_mem,
    input  ready_ex, valid_mem, ctrl_mem, inst_11_to_7_mem, inst_14_to_12_mem,
           jump_alu_result_mem, address_alu_result_mem, address_alu_zero_mem, read_data_2_mem
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready back-pressure, flush, optional skid entry
// and a saturating back-pressure cycle counter.
module ex_mem_pipe_stage #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10,
  parameter int CTRL_W    = 8,
  parameter int SKID      = 1
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        flush,
  ex_mem_if.slave     bus,
  output logic [15:0] stall_cycles,
  output logic [1:0]  o_state_dbg
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKIDFULL = 2'd2} state_t;

  typedef struct packed {
    logic [CTRL_W-1:0]    ctrl;
    logic [4:0]           rd;
    logic [2:0]           funct3;
    logic [ADDR_SIZE+1:0] jump;
    logic [DATA_SIZE-1:0] addr;
    logic                 zero;
    logic [DATA_SIZE-1:0] store;
  } beat_t;

  state_t      r_state;
  beat_t       r_main;
  beat_t       r_skid;
  logic        r_ready;
  logic [15:0] r_stall;
  beat_t       w_in;
  logic        w_valid_mem;

  assign w_in = {bus.ctrl_ex, bus.inst_11_to_7_ex, bus.inst_14_to_12_ex, bus.jump_alu_result_ex,
                 bus.address_alu_result_ex, bus.address_alu_zero_ex, bus.read_data_2_ex};

  assign w_valid_mem = (r_state != EMPTY);

  // The skid build decouples ready_ex from ready_mem through r_ready; without it the path is combinational.
  assign bus.ready_ex = (SKID != 0) ? r_ready : (bus.ready_mem | ~w_valid_mem);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b1;
      r_stall <= '0;
    end else begin
      if (w_valid_mem && !bus.ready_mem && !flush && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
      if (flush) begin
        r_state <= EMPTY;
        r_ready <= 1'b1;
      end else begin
        case (r_state)
          EMPTY: begin
            if (bus.valid_ex) begin
              r_main  <= w_in;
              r_state <= FULL;
            end
          end
          FULL: begin
            if (bus.ready_mem) begin
              if (bus.valid_ex) r_main <= w_in;
              else              r_state <= EMPTY;
            end else if (bus.valid_ex && SKID != 0) begin
              r_skid  <= w_in;
              r_state <= SKIDFULL;
              r_ready <= 1'b0;
            end
          end
          SKIDFULL: begin
            if (bus.ready_mem) begin
              r_main  <= r_skid;
              r_state <= FULL;
              r_ready <= 1'b1;
            end
          end
          default: begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  // Control is gated so MEM never acts on a stale beat; payload is left ungated.
  assign bus.valid_mem              = w_valid_mem;
  assign bus.ctrl_mem               = w_valid_mem ? r_main.ctrl : '0;
  assign bus.inst_11_to_7_mem       = r_main.rd;
  assign bus.inst_14_to_12_mem      = r_main.funct3;
  assign bus.jump_alu_result_mem    = r_main.jump;
  assign bus.address_alu_result_mem = r_main.addr;
  assign bus.address_alu_zero_mem   = r_main.zero;
  assign bus.read_data_2_mem        = r_main.store;
  assign stall_cycles               = r_stall;
  assign o_state_dbg                = r_state;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: a SKID=1/ADDR_SIZE=10 instance and a SKID=0/ADDR_SIZE=12 instance,
// one driven at a time through shared stimulus and checked against a beat queue.
module tb_ex_mem_pipe_stage;

  logic        clk = 1'b0;
  logic        d_clear, d_flush, d_valid, d_ready_mem, sel;
  logic [7:0]  d_ctrl;
  logic [4:0]  d_rd;
  logic [2:0]  d_f3;
  logic [13:0] d_jump;
  logic [31:0] d_addr;
  logic        d_zero;
  logic [31:0] d_rd2;

  logic [15:0] stall1, stall0;
  logic [1:0]  state1, state0;

  logic        o_valid, o_ready_ex, o_zero;
  logic [7:0]  o_ctrl;
  logic [4:0]  o_rd;
  logic [2:0]  o_f3;
  logic [13:0] o_jump;
  logic [31:0] o_addr, o_rd2;
  logic [15:0] o_stall;

  int checks = 0;
  int errors = 0;
  logic [94:0] exp_q[$];
  logic [15:0] exp_stall = 16'd0;

  always #5 clk = ~clk;

  ex_mem_if #(.DATA_SIZE(32), .ADDR_SIZE(10), .CTRL_W(8)) bus1 ();
  ex_mem_if #(.DATA_SIZE(32), .ADDR_SIZE(12), .CTRL_W(8)) bus0 ();

  assign bus1.valid_ex              = d_valid & ~sel;
  assign bus1.ctrl_ex               = d_ctrl;
  assign bus1.inst_11_to_7_ex       = d_rd;
  assign bus1.inst_14_to_12_ex      = d_f3;
  assign bus1.jump_alu_result_ex    = d_jump[11:0];
  assign bus1.address_alu_result_ex = d_addr;
  assign bus1.address_alu_zero_ex   = d_zero;
  assign bus1.read_data_2_ex        = d_rd2;
  assign bus1.ready_mem             = d_ready_mem;

  assign bus0.valid_ex              = d_valid & sel;
  assign bus0.ctrl_ex               = d_ctrl;
  assign bus0.inst_11_to_7_ex       = d_rd;
  assign bus0.inst_14_to_12_ex      = d_f3;
  assign bus0.jump_alu_result_ex    = d_jump;
  assign bus0.address_alu_result_ex = d_addr;
  assign bus0.address_alu_zero_ex   = d_zero;
  assign bus0.read_data_2_ex        = d_rd2;
  assign bus0.ready_mem             = d_ready_mem;

  ex_mem_pipe_stage #(.DATA_SIZE(32), .ADDR_SIZE(10), .CTRL_W(8), .SKID(1)) u_dut1 (
    .clk(clk), .clear(d_clear), .flush(d_flush), .bus(bus1),
    .stall_cycles(stall1), .o_state_dbg(state1));

  ex_mem_pipe_stage #(.DATA_SIZE(32), .ADDR_SIZE(12), .CTRL_W(8), .SKID(0)) u_dut0 (
    .clk(clk), .clear(d_clear), .flush(d_flush), .bus(bus0),
    .stall_cycles(stall0), .o_state_dbg(state0));

  assign o_valid    = sel ? bus0.valid_mem : bus1.valid_mem;
  assign o_ready_ex = sel ? bus0.ready_ex : bus1.ready_ex;
  assign o_ctrl     = sel ? bus0.ctrl_mem : bus1.ctrl_mem;
  assign o_rd       = sel ? bus0.inst_11_to_7_mem : bus1.inst_11_to_7_mem;
  assign o_f3       = sel ? bus0.inst_14_to_12_mem : bus1.inst_14_to_12_mem;
  assign o_jump     = sel ? bus0.jump_alu_result_mem : {2'b00, bus1.jump_alu_result_mem};
  assign o_addr     = sel ? bus0.address_alu_result_mem : bus1.address_alu_result_mem;
  assign o_zero     = sel ? bus0.address_alu_zero_mem : bus1.address_alu_zero_mem;
  assign o_rd2      = sel ? bus0.read_data_2_mem : bus1.read_data_2_mem;
  assign o_stall    = sel ? stall0 : stall1;

  // Scoreboard / model: runs on the falling edge, between the bench's input updates.
  always @(negedge clk) begin
    logic [94:0] act, exp;
    checks++;
    if (o_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL valid_track: got %b expected %b at %0t", o_valid, exp_q.size() != 0, $time);
    end
    if (d_clear || d_flush) begin
      exp_q.delete();
      if (d_clear) exp_stall = 16'd0;
    end else begin
      if (exp_q.size() != 0 && !d_ready_mem && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (o_valid && d_ready_mem) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got addr %h expected no beat at %0t", o_addr, $time);
        end else begin
          exp = exp_q.pop_front();
          act = {o_ctrl, o_rd, o_f3, o_jump, o_addr, o_zero, o_rd2};
          if (act !== exp) begin
            errors++;
            $display("FAIL beat_data: got %h expected %h at %0t", act, exp, $time);
          end
        end
      end
      if (d_valid && o_ready_ex)
        exp_q.push_back({d_ctrl, d_rd, d_f3, sel ? d_jump : {2'b00, d_jump[11:0]}, d_addr, d_zero, d_rd2});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] addr);
    d_ctrl  = 8'($urandom_range(1, 255));
    d_rd    = 5'($urandom);
    d_f3    = 3'($urandom);
    d_jump  = 14'($urandom);
    d_addr  = addr;
    d_zero  = 1'($urandom);
    d_rd2   = $urandom;
    d_valid = 1'b1;
  endtask

  task automatic wait_accept();
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 50; k++) begin
      acc = o_ready_ex;
      step();
      if (acc) break;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: got ready_ex %b expected 1 within 50 cycles", o_ready_ex);
    end
  endtask

  task automatic drain();
    d_valid     = 1'b0;
    d_ready_mem = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (exp_q.size() == 0) break;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d queued expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    d_valid = 1'b0; d_flush = 1'b0; d_ready_mem = 1'b0; d_clear = 1'b1;
    step();
    d_clear = 1'b0;
    step();
    checks++;
    if ({o_valid, o_ctrl, o_stall, o_ready_ex} !== {1'b0, 8'h00, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL reset: got v=%b ctrl=%h stall=%h rdy=%b expected v=0 ctrl=00 stall=0000 rdy=1",
               o_valid, o_ctrl, o_stall, o_ready_ex);
    end
    checks++;
    if ({o_addr, o_rd2, o_jump} !== '0) begin
      errors++;
      $display("FAIL reset_payload: got %h expected 0", {o_addr, o_rd2, o_jump});
    end
  endtask

  task automatic test_stream(input logic [31:0] base);
    d_ready_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_beat(base + 32'(i));
      wait_accept();
      checks++;
      if (o_valid !== 1'b1 || o_addr !== base + 32'(i)) begin
        errors++;
        $display("FAIL stream_latency: got v=%b addr=%h expected v=1 addr=%h", o_valid, o_addr, base + 32'(i));
      end
    end
    drain();
  endtask

  task automatic test_skid();
    d_ready_mem = 1'b0;
    set_beat(32'h20);
    wait_accept();
    checks++;
    if (o_ready_ex !== 1'b1) begin
      errors++;
      $display("FAIL skid_ready_full: got %b expected 1", o_ready_ex);
    end
    set_beat(32'h21);
    step();
    set_beat(32'h22);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_ready_ex !== 1'b0 || o_addr !== 32'h20 || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL skid_hold: got rdy=%b v=%b addr=%h expected rdy=0 v=1 addr=20", o_ready_ex, o_valid, o_addr);
      end
      step();
    end
    d_ready_mem = 1'b1;
    wait_accept();
    drain();
    checks++;
    if (o_stall !== exp_stall || o_stall !== 16'd5) begin
      errors++;
      $display("FAIL skid_stall_count: got %0d expected %0d", o_stall, exp_stall);
    end
  endtask

  task automatic test_comb_ready();
    d_ready_mem = 1'b0;
    set_beat(32'h70);
    d_jump = 14'h3ABC;
    wait_accept();
    checks++;
    if (o_jump !== 14'h3ABC || o_ready_ex !== 1'b0) begin
      errors++;
      $display("FAIL comb_jump14: got jump=%h rdy=%b expected jump=3abc rdy=0", o_jump, o_ready_ex);
    end
    set_beat(32'h71);
    #1;
    d_ready_mem = 1'b1;
    #1;
    checks++;
    if (o_ready_ex !== 1'b1) begin
      errors++;
      $display("FAIL comb_ready_rise: got %b expected 1", o_ready_ex);
    end
    d_ready_mem = 1'b0;
    #1;
    checks++;
    if (o_ready_ex !== 1'b0) begin
      errors++;
      $display("FAIL comb_ready_fall: got %b expected 0", o_ready_ex);
    end
    step();
    step();
    checks++;
    if (o_addr !== 32'h70 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL comb_hold: got v=%b addr=%h expected v=1 addr=70", o_valid, o_addr);
    end
    d_ready_mem = 1'b1;
    wait_accept();
    set_beat(32'h72);
    wait_accept();
    drain();
  endtask

  task automatic test_flush();
    d_ready_mem = 1'b0;
    set_beat(32'h30);
    wait_accept();
    if (!sel) begin
      set_beat(32'h31);
      wait_accept();
    end
    set_beat(32'h32);
    d_flush = 1'b1;
    step();
    d_flush = 1'b0;
    d_valid = 1'b0;
    checks++;
    if ({o_valid, o_ctrl, o_ready_ex} !== {1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL flush: got v=%b ctrl=%h rdy=%b expected v=0 ctrl=00 rdy=1", o_valid, o_ctrl, o_ready_ex);
    end
    d_ready_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (o_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_reappear: got %b expected 0", o_valid);
      end
    end
  endtask

  task automatic test_clear_flush();
    d_ready_mem = 1'b1;
    set_beat(32'h50);
    wait_accept();
    set_beat(32'h51);
    wait_accept();
    set_beat(32'h52);
    d_clear = 1'b1;
    d_flush = 1'b1;
    step();
    d_clear = 1'b0;
    d_flush = 1'b0;
    d_valid = 1'b0;
    checks++;
    if ({o_valid, o_ctrl, o_stall, o_ready_ex, o_addr, o_rd2} !== {1'b0, 8'h00, 16'h0000, 1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL clear_flush: got v=%b ctrl=%h stall=%h rdy=%b addr=%h expected v=0 ctrl=00 stall=0 rdy=1 addr=0",
               o_valid, o_ctrl, o_stall, o_ready_ex, o_addr);
    end
  endtask

  task automatic test_saturation();
    d_ready_mem = 1'b0;
    set_beat(32'h60);
    wait_accept();
    d_valid = 1'b0;
    repeat (65540) step();
    checks++;
    if (o_stall !== 16'hFFFF || exp_stall !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_saturate: got %h expected ffff (model %h)", o_stall, exp_stall);
    end
    checks++;
    if (o_addr !== 32'h60 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL saturate_hold: got v=%b addr=%h expected v=1 addr=60", o_valid, o_addr);
    end
  endtask

  initial begin
    sel = 1'b0; d_clear = 1'b1; d_flush = 1'b0; d_valid = 1'b0; d_ready_mem = 1'b0;
    d_ctrl = '0; d_rd = '0; d_f3 = '0; d_jump = '0; d_addr = '0; d_zero = 1'b0; d_rd2 = '0;
    test_reset();
    test_stream(32'h10);
    test_skid();
    test_flush();
    test_clear_flush();
    test_saturation();
    test_reset();
    sel = 1'b1;
    test_reset();
    test_stream(32'h10);
    test_comb_ready();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
